exhaustive_stim_gen: RTL and testbench
======================================

EXHAUSTIVE_STIM_GEN -- requirements
Module: exhaustive_stim_gen

Interface
REQ-001 Parameter WIDTH, default 4: stimulus vector width, range 1..8.
REQ-002 Parameter HOLD, default 5: clock cycles each vector is held, range 1..255.
REQ-003 Parameter MODE, default 0: vector ordering, 0 = binary ascending, 1 = Gray code.
REQ-004 Parameter EXPECTED, default 0: 2**WIDTH-bit golden truth table, used only under CHECK_EN.
REQ-005 One clock; reset is asynchronous and active-high; ports clk_i and rst_i.
REQ-006 clk_i  input  1  rising-edge clock.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 start_i  input  1  start a sweep, sampled when in IDLE or DONE.
REQ-009 resp_i  input  1  DUT response to vec_o.
REQ-010 vec_o  output  WIDTH  stimulus vector to the DUT.
REQ-011 busy_o  output  1  high while a sweep runs.
REQ-012 done_o  output  1  high once a sweep has completed, until the next start or reset.
REQ-013 table_o  output  2**WIDTH  captured truth table; bit v holds resp_i sampled while vec_o == v.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start_i.
- RUN->DONE after the last vector is captured.
- DONE->RUN on start_i.
REQ-015 On the edge that enters RUN, SHALL set index to 0, vec_o = code(0), hold count to 0, and table_o to all zeros.
REQ-016 In RUN, hold count SHALL increment each cycle; at hold count == HOLD-1 the block SHALL write resp_i into table_o[vec_o], reset hold count, and advance the index.
REQ-017 code(i) SHALL be i for MODE 0 and i ^ (i >> 1) for MODE 1; vec_o is registered.
REQ-018 Capture of the final index 2**WIDTH-1 SHALL move to DONE on the same edge: busy_o = 0, done_o = 1, vec_o holds the last vector.
REQ-019 Sweep length SHALL be exactly HOLD * 2**WIDTH cycles from the start edge to the edge asserting done_o.
REQ-020 start_i SHALL be ignored in RUN.
REQ-021 HOLD = 1 SHALL give a new vector and a capture every cycle with no bubble.
REQ-022 The index counter SHALL be WIDTH+1 bits so the terminal count does not alias to 0.

Reset
REQ-023 rst_i SHALL immediately force IDLE with vec_o = 0, busy_o = 0, done_o = 0, table_o = 0, index and hold count = 0, and mismatch outputs = 0, including mid-sweep.
REQ-024 The first start_i after reset release SHALL begin a full sweep from index 0.

Configuration
REQ-025 Macro EXHAUSTIVE_STIM_GEN_CHECK_EN SHALL compile in a checker.
- Defined: add outputs mismatch_o (1 bit) and err_idx_o (WIDTH bits).
- On entry to DONE, mismatch_o = (table_o != EXPECTED).
- err_idx_o = lowest index v with table_o[v] != EXPECTED[v], else 0.
- Both outputs clear on start_i and on reset.
REQ-026 Without the macro, those ports and that logic SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Shared package stim_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the MODE constants (MODE_BIN = 0, MODE_GRAY = 1).
REQ-028 Binary-to-Gray conversion SHALL be a sub-module bin2gray, parametrised by WIDTH and purely combinational.

Verification
REQ-029 WIDTH=4, HOLD=5, MODE=0, resp_i = AND of vec_o bits, start pulse -> vec_o steps 0..F every 5 cycles; done_o at cycle 80; table_o = 16'h8000.
REQ-030 MODE=1, HOLD=1, resp_i = vec_o[0] -> vec_o sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; done_o at cycle 16; table_o = 16'hAAAA.
REQ-031 Assert rst_i asynchronously while vec_o = 7 -> all outputs 0 before the next edge; a new start_i restarts at vec_o = 0.
REQ-032 start_i pulsed at cycle 20 of a sweep -> no effect; done_o still at cycle 80.
REQ-033 CHECK_EN, EXPECTED = 16'h8000, resp_i = OR of vec_o bits -> mismatch_o = 1, err_idx_o = 1 at done.
REQ-034 start_i in DONE -> table_o clears, done_o drops, busy_o rises on the same edge, and the sweep repeats with identical results.

Source files
------------

// File: rtl/exhaustive_stim_gen_pkg.sv
// Shared types and constants for the exhaustive stimulus generator.
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MODE_BIN  = 0;
  localparam int unsigned MODE_GRAY = 1;

endpackage

// File: rtl/exhaustive_stim_gen_bin2gray.sv
// Purely combinational binary-to-Gray converter.
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Reflected binary code: each bit XORed with its higher neighbour.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/exhaustive_stim_gen.sv
// Exhaustive stimulus generator: sweeps every WIDTH-bit vector (binary or
// Gray order), holds each for HOLD cycles and captures the DUT response
// into a truth table. Define EXHAUSTIVE_STIM_GEN_CHECK_EN to add a
// golden-table checker (mismatch_o, err_idx_o).
module exhaustive_stim_gen
  import stim_pkg::*;
#(
  parameter int unsigned            WIDTH    = 4,
  parameter int unsigned            HOLD     = 5,
  parameter int unsigned            MODE     = MODE_BIN,
  parameter logic [2**WIDTH-1:0]    EXPECTED = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 resp_i,
  output logic [WIDTH-1:0]     vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2**WIDTH-1:0]  table_o
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
  ,
  output logic                 mismatch_o,
  output logic [WIDTH-1:0]     err_idx_o
`endif
);

  localparam int unsigned DEPTH     = 2**WIDTH;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD - 1);

  state_t             state;
  logic [WIDTH:0]     idx;
  logic [WIDTH:0]     idx_nxt;
  logic [7:0]         hold_cnt;
  logic [WIDTH-1:0]   bin_nxt;
  logic [WIDTH-1:0]   gray_nxt;
  logic [WIDTH-1:0]   code_nxt;
  logic [DEPTH-1:0]   table_nxt;
  logic               capture;
  logic               last_capture;
  logic               start_accept;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // Next index/code, capture strobe and the table including this cycle's sample.
  // The terminal capture is detected from the carry into the extra index bit.
  always_comb begin
    idx_nxt      = idx + 1'b1;
    bin_nxt      = idx_nxt[WIDTH-1:0];
    code_nxt     = (MODE == MODE_GRAY) ? gray_nxt : bin_nxt;
    capture      = (state == RUN) && (hold_cnt == HOLD_LAST);
    last_capture = capture && idx_nxt[WIDTH];
    start_accept = start_i && ((state == IDLE) || (state == DONE));
    table_nxt    = table_o;
    if (capture) begin
      table_nxt[vec_o] = resp_i;
    end
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      vec_o    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      table_o  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state    <= RUN;
            idx      <= '0;
            hold_cnt <= '0;
            vec_o    <= '0;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            table_o  <= '0;
          end
        end
        RUN: begin
          table_o <= table_nxt;
          if (capture) begin
            hold_cnt <= '0;
            idx      <= idx_nxt;
            if (last_capture) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              vec_o <= code_nxt;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
  logic [DEPTH-1:0] diff;
  logic [WIDTH-1:0] err_nxt;
  logic             found;

  // Lowest differing index of the completed table against the golden table.
  always_comb begin
    diff    = table_nxt ^ EXPECTED;
    err_nxt = '0;
    found   = 1'b0;
    for (int unsigned v = 0; v < DEPTH; v++) begin
      if (diff[v] && !found) begin
        err_nxt = WIDTH'(v);
        found   = 1'b1;
      end
    end
  end

  // Checker result latched on entry to DONE, cleared by an accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_o <= 1'b0;
      err_idx_o  <= '0;
    end else if (start_accept) begin
      mismatch_o <= 1'b0;
      err_idx_o  <= '0;
    end else if (last_capture) begin
      mismatch_o <= |diff;
      err_idx_o  <= err_nxt;
    end
  end
`else
  logic unused_expected;

  // Golden table only matters to the checker.
  always_comb begin
    unused_expected = ^{EXPECTED, start_accept};
  end
`endif

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Directed, scoreboard-based bench for exhaustive_stim_gen (binary/HOLD=5
// and Gray/HOLD=1 instances).
module tb_exhaustive_stim_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_b, start_g;
  logic        resp_b, resp_g;
  logic        resp_or;
  logic [3:0]  vec_b, vec_g;
  logic        busy_b, busy_g, done_b, done_g;
  logic [15:0] table_b, table_g;
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
  logic        mis_b, mis_g;
  logic [3:0]  err_b, err_g;
`endif

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  assign resp_b = resp_or ? (|vec_b) : (&vec_b);
  assign resp_g = vec_g[0];

  exhaustive_stim_gen #(.WIDTH(4), .HOLD(5), .MODE(0), .EXPECTED(16'h8000)) u_bin (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .resp_i(resp_b),
    .vec_o(vec_b), .busy_o(busy_b), .done_o(done_b), .table_o(table_b)
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
    , .mismatch_o(mis_b), .err_idx_o(err_b)
`endif
  );

  exhaustive_stim_gen #(.WIDTH(4), .HOLD(1), .MODE(1), .EXPECTED(16'hAAAA)) u_gray (
    .clk_i(clk), .rst_i(rst), .start_i(start_g), .resp_i(resp_g),
    .vec_o(vec_g), .busy_o(busy_g), .done_o(done_g), .table_o(table_g)
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
    , .mismatch_o(mis_g), .err_idx_o(err_g)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full binary sweep; optional start pulse at cycle 20 must be ignored.
  task automatic sweep_bin(input logic [15:0] exp_tab, input bit mid_start,
                           input bit exp_mis, input logic [3:0] exp_err);
    int k;
    for (int i = 0; i < 80; i++) exp_q.push_back(4'(i / 5));
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    check("bin_start_table", table_b, 16'h0);
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
    check("bin_start_mis", mis_b, 0);
    check("bin_start_err", err_b, 0);
`endif
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      check("bin_vec", vec_b, exp_q.pop_front());
      check("bin_busy", busy_b, 1);
      check("bin_done", done_b, 0);
      if (mid_start && k == 20) start_b = 1'b1;
      if (k == 21) start_b = 1'b0;
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
      k++;
    end
    check("bin_sweep_len", k, 80);
    @(posedge clk); #1;
    check("bin_done_at_80", done_b, 1);
    check("bin_busy_end", busy_b, 0);
    check("bin_vec_end", vec_b, 4'hF);
    check("bin_table", table_b, exp_tab);
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
    check("bin_mismatch", mis_b, exp_mis);
    check("bin_err_idx", err_b, exp_err);
`else
    if (exp_mis && exp_err != 4'h0) check("bin_unused_args", 0, 0 + 0);
`endif
    repeat (3) @(posedge clk);
    #1 check("bin_done_hold", done_b, 1);
  endtask

  logic [3:0] gray_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    int k;
    rst = 1'b1; start_b = 1'b0; start_g = 1'b0; resp_or = 1'b0;
    #1;
    check("rst_vec", vec_b, 0);
    check("rst_busy", busy_b, 0);
    check("rst_done", done_b, 0);
    check("rst_table", table_b, 0);
    check("rst_vec_g", vec_g, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Binary, AND response, ignored mid-sweep start.
    sweep_bin(16'h8000, 1'b1, 1'b0, 4'h0);

    // Restart from DONE: same-edge clear, identical results.
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    check("restart_done_drop", done_b, 0);
    check("restart_busy", busy_b, 1);
    check("restart_table_clr", table_b, 0);
    check("restart_vec", vec_b, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    sweep_bin(16'h8000, 1'b0, 1'b0, 4'h0);

    // OR response: table FFFE, checker flags index 1.
    resp_or = 1'b1;
    sweep_bin(16'hFFFE, 1'b0, 1'b1, 4'h1);

    // Asynchronous reset mid-sweep while vec_o == 7.
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (36) @(posedge clk);
    #1 check("pre_rst_vec", vec_b, 4'h7);
    check("pre_rst_table", table_b, 16'h007E);
    #1 rst = 1'b1;
    #1;
    check("arst_vec", vec_b, 0);
    check("arst_busy", busy_b, 0);
    check("arst_done", done_b, 0);
    check("arst_table", table_b, 0);
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
    check("arst_mis", mis_b, 0);
    check("arst_err", err_b, 0);
`endif
    @(negedge clk) rst = 1'b0;
    resp_or = 1'b0;
    sweep_bin(16'h8000, 1'b0, 1'b0, 4'h0);

    // Gray ordering, HOLD=1: new vector every cycle.
    for (int i = 0; i < 16; i++) exp_q.push_back(gray_seq[i]);
    @(negedge clk) start_g = 1'b1;
    @(posedge clk); #1 start_g = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      check("gray_vec", vec_g, exp_q.pop_front());
      check("gray_busy", busy_g, 1);
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
      k++;
    end
    check("gray_sweep_len", k, 16);
    @(posedge clk); #1;
    check("gray_done_at_16", done_g, 1);
    check("gray_busy_end", busy_g, 0);
    check("gray_vec_end", vec_g, 4'h8);
    check("gray_table", table_g, 16'hAAAA);
`ifdef EXHAUSTIVE_STIM_GEN_CHECK_EN
    check("gray_mismatch", mis_g, 0);
    check("gray_err", err_g, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
